// File: rtl/matrix_uart_printer.sv
// Streams a packed m x n matrix of 8-bit values to a UART TX byte port
// as decimal text: space-separated elements, CR LF after each row.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             print request, sampled only when idle
//   matrix_flat       row-major elements, element 0 in bits [7:0]
//   m, n              row and column counts, 1..MAX_DIM
//   tx_data/tx_valid  byte offered to the transmitter
//   tx_ready          transmitter accepts the offered byte
//   busy              print in progress
//   done              pulse after the last LF is accepted
//   error             pulse when the requested size is illegal
module matrix_uart_printer #(
  parameter int          MAX_DIM  = 5,
  parameter logic [7:0]  SEP_CHAR = 8'h20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MAX_DIM*MAX_DIM*8-1:0] matrix_flat,
  input  logic [2:0]                   m,
  input  logic [2:0]                   n,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int         W    = MAX_DIM * MAX_DIM * 8;
  localparam int         IW   = $clog2(MAX_DIM * MAX_DIM);
  localparam int         BW   = IW + 3;
  localparam logic [2:0] LMAX = 3'(MAX_DIM);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SEND_DIG,
    SEND_SEP,
    SEND_CR,
    SEND_LF,
    DONE,
    ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0] r_mat;
  logic [2:0]   r_m;
  logic [2:0]   r_n;
  logic [2:0]   r_i;
  logic [2:0]   r_j;
  logic [7:0]   r_d0;
  logic [7:0]   r_d1;
  logic [7:0]   r_d2;
  logic [1:0]   r_didx;
  logic [1:0]   r_dlast;

  logic          w_bad;
  logic [IW-1:0] w_idx;
  logic [BW-1:0] w_bit;
  logic [7:0]    w_elem;
  logic [7:0]    w_hun;
  logic [7:0]    w_ten;
  logic [7:0]    w_one;
  logic          w_hs;
  logic          w_last_dig;
  logic          w_more_col;
  logic          w_more_row;

  assign w_bad = (m == 3'd0) || (n == 3'd0) ||
                 (m > LMAX) || (n > LMAX);

  assign w_idx  = IW'(r_i) * IW'(r_n) + IW'(r_j);
  assign w_bit  = {w_idx, 3'b000};
  assign w_elem = r_mat[w_bit +: 8];

  assign w_hun = (w_elem / 8'd100) + 8'h30;
  assign w_ten = ((w_elem / 8'd10) % 8'd10) + 8'h30;
  assign w_one = (w_elem % 8'd10) + 8'h30;

  assign w_hs       = tx_valid && tx_ready;
  assign w_last_dig = (r_didx == r_dlast);
  assign w_more_col = (r_j + 3'd1) < r_n;
  assign w_more_row = (r_i + 3'd1) < r_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_bad ? ERR : CONV;
        end
      end
      CONV:     w_next = SEND_DIG;
      SEND_DIG: begin
        if (tx_ready && w_last_dig) begin
          w_next = w_more_col ? SEND_SEP : SEND_CR;
        end
      end
      SEND_SEP: if (tx_ready) w_next = CONV;
      SEND_CR:  if (tx_ready) w_next = SEND_LF;
      SEND_LF: begin
        if (tx_ready) begin
          w_next = w_more_row ? CONV : DONE;
        end
      end
      DONE:     w_next = IDLE;
      ERR:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (r_state)
      IDLE: ;
      CONV: busy = 1'b1;
      SEND_DIG: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        unique case (r_didx)
          2'd0:    tx_data = r_d0;
          2'd1:    tx_data = r_d1;
          default: tx_data = r_d2;
        endcase
      end
      SEND_SEP: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = SEP_CHAR;
      end
      SEND_CR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
      end
      SEND_LF: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
      end
      DONE:    done  = 1'b1;
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat   <= '0;
      r_m     <= 3'd0;
      r_n     <= 3'd0;
      r_i     <= 3'd0;
      r_j     <= 3'd0;
      r_d0    <= 8'h00;
      r_d1    <= 8'h00;
      r_d2    <= 8'h00;
      r_didx  <= 2'd0;
      r_dlast <= 2'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start && !w_bad) begin
            r_mat <= matrix_flat;
            r_m   <= m;
            r_n   <= n;
            r_i   <= 3'd0;
            r_j   <= 3'd0;
          end
        end
        CONV: begin
          // Digits are stored most significant first so
          // SEND_DIG just walks r_didx up to r_dlast.
          r_didx <= 2'd0;
          if (w_elem >= 8'd100) begin
            r_d0    <= w_hun;
            r_d1    <= w_ten;
            r_d2    <= w_one;
            r_dlast <= 2'd2;
          end else if (w_elem >= 8'd10) begin
            r_d0    <= w_ten;
            r_d1    <= w_one;
            r_d2    <= 8'h30;
            r_dlast <= 2'd1;
          end else begin
            r_d0    <= w_one;
            r_d1    <= 8'h30;
            r_d2    <= 8'h30;
            r_dlast <= 2'd0;
          end
        end
        SEND_DIG: begin
          if (w_hs && !w_last_dig) begin
            r_didx <= r_didx + 2'd1;
          end
        end
        SEND_SEP: begin
          if (w_hs) r_j <= r_j + 3'd1;
        end
        SEND_LF: begin
          if (w_hs && w_more_row) begin
            r_i <= r_i + 3'd1;
            r_j <= 3'd0;
          end
        end
        DONE: begin
          r_i <= 3'd0;
          r_j <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Bench for matrix_uart_printer: a string-level model of the
// printed text feeds a byte scoreboard checked every cycle.
module tb_matrix_uart_printer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [199:0] matrix_flat = '0;
  logic [2:0]   m = 3'd1;
  logic [2:0]   n = 3'd1;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         busy;
  logic         done;
  logic         error;

  matrix_uart_printer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_flat (matrix_flat),
    .m           (m),
    .n           (n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  int  hs_cnt  = 0;
  int  gap_cnt = 0;
  int  hs_base = 0;
  int  gap_base = 0;

  int  mode = 0;
  int  stall_left = 0;
  int  stalled_idx = -1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic string model(input logic [199:0] mat,
                                  input int mm,
                                  input int nn);
    string s;
    s = "";
    for (int r = 0; r < mm; r++) begin
      for (int c = 0; c < nn; c++) begin
        s = {s, $sformatf("%0d", mat[(r*nn+c)*8 +: 8])};
        if (c < nn - 1) s = {s, " "};
      end
      s = {s, $sformatf("%c%c", 8'd13, 8'd10)};
    end
    return s;
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid) chk("busy_with_valid", 32'(busy), 32'd1);
      if (busy && !tx_valid) gap_cnt++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %02h required none",
                   tx_data);
        end else begin
          chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        hs_cnt++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // Backpressure: in mode 1 hold ready low 5 cycles whenever
  // the next byte to go is every 3rd byte of the stream.
  always @(posedge clk) begin
    #1;
    if (mode == 1 && stall_left == 0 &&
        hs_cnt % 3 == 2 && stalled_idx != hs_cnt) begin
      stall_left  = 5;
      stalled_idx = hs_cnt;
    end
    if (stall_left > 0) begin
      tx_ready = 1'b0;
      stall_left--;
    end else begin
      tx_ready = 1'b1;
    end
  end

  task automatic start_print(input logic [199:0] mat,
                             input int mm,
                             input int nn);
    string s;
    s = model(mat, mm, nn);
    for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    hs_base     = hs_cnt;
    gap_base    = gap_cnt;
    matrix_flat = mat;
    m           = 3'(mm);
    n           = 3'(nn);
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid", 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("t2_valid", 32'(tx_valid), 32'd1);
    chk("t2_first", 32'(tx_data), 32'(s[0]));
  endtask

  task automatic wait_done(input int nbytes, input int nelem);
    bit seen;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("bytes", 32'(hs_cnt - hs_base), 32'(nbytes));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("gaps", 32'(gap_cnt - gap_base), 32'(nelem));
    @(negedge clk);
    chk("done_1cyc", 32'(done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [199:0] mat23;
  logic [199:0] mat11;
  logic [199:0] mat55;
  logic [199:0] mat_alt;
  string        lit;

  initial begin
    mat11 = '0;
    mat11[7:0] = 8'd7;
    mat23 = '0;
    mat23[7:0]   = 8'd0;
    mat23[15:8]  = 8'd10;
    mat23[23:16] = 8'd255;
    mat23[31:24] = 8'd9;
    mat23[39:32] = 8'd100;
    mat23[47:40] = 8'd42;
    mat55 = '0;
    for (int k = 0; k < 25; k++) mat55[k*8 +: 8] = 8'd200;
    mat_alt = '0;
    for (int k = 0; k < 25; k++) mat_alt[k*8 +: 8] = 8'd1;

    // Model pins against hand-written text.
    lit = $sformatf("0 10 255%c%c9 100 42%c%c", 8'd13, 8'd10,
                    8'd13, 8'd10);
    checks++;
    if (model(mat23, 2, 3) != lit) begin
      errors++;
      $display("FAIL model_2x3: got %s", model(mat23, 2, 3));
    end
    lit = $sformatf("7%c%c", 8'd13, 8'd10);
    checks++;
    if (model(mat11, 1, 1) != lit) begin
      errors++;
      $display("FAIL model_1x1: got %s", model(mat11, 1, 1));
    end
    chk("model_len_5x5", 32'(model(mat55, 5, 5).len()), 32'd105);

    // Reset state.
    #2;
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1x1, element 7.
    start_print(mat11, 1, 1);
    wait_done(3, 1);

    // 2x3 with ready high.
    start_print(mat23, 2, 3);
    wait_done(20, 6);

    // 2x3 with backpressure.
    mode = 1;
    start_print(mat23, 2, 3);
    wait_done(20, 6);
    mode = 0;
    repeat (6) @(posedge clk);
    #1;

    // Illegal sizes: m=0 then n=6.
    for (int t = 0; t < 2; t++) begin
      m = (t == 0) ? 3'd0 : 3'd2;
      n = (t == 0) ? 3'd2 : 3'd6;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("err_pulse", 32'(error), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_valid", 32'(tx_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("err_1cyc", 32'(error), 32'd0);
      chk("err_busy2", 32'(busy), 32'd0);
    end

    // Legal print right after an error.
    start_print(mat11, 1, 1);
    wait_done(3, 1);

    // 5x5 of 200 with start pulses and input changes mid-print.
    start_print(mat55, 5, 5);
    repeat (10) @(posedge clk);
    #1;
    matrix_flat = mat_alt;
    m = 3'd2;
    n = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(105, 25);
    repeat (4) @(posedge clk);
    #1;
    chk("no_queued_start", 32'(busy), 32'd0);

    // Reset after the 4th byte of the 2x3 case.
    start_print(mat23, 2, 3);
    for (int c = 0; c < 200 && (hs_cnt - hs_base) < 4; c++)
      @(negedge clk);
    chk("four_bytes", 32'(hs_cnt - hs_base), 32'd4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'h00);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_print(mat23, 2, 3);
    wait_done(20, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
